// File: rtl/mac_rx_frame_reader.sv
// rtl/mac_rx_frame_reader.sv - pops rx descriptors and streams each frame's bytes downstream
// Errored or zero-length frames are read out of the data FIFO and dropped, with a count kept.
module mac_rx_frame_reader #(
  parameter int LEN_W = 12,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn_sys,
  output logic             rx_ptr_fifo_rd,
  input  logic [19:0]      rx_ptr_fifo_dout,
  input  logic             rx_ptr_fifo_empty,
  output logic             rx_data_fifo_rd,
  input  logic [7:0]       rx_data_fifo_dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_sof,
  output logic             out_eof,
  output logic [6:0]       out_meta,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic [2:0] {IDLE, PTR_WAIT, STREAM, DRAIN, DONE} state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [6:0]       meta_q, meta_d;
  logic             sof_pend_q, sof_pend_d;
  logic             infl_q, infl_d;
  logic             infl_sof_q, infl_sof_d;
  logic             infl_eof_q, infl_eof_d;
  logic [1:0]       occ_q, occ_d;
  logic [1:0][9:0]  skid_q, skid_d;
  logic [CNT_W-1:0] frame_q, frame_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic       pop;
  logic       stream_rd;
  logic       drain_rd;
  logic       ins_hi;
  logic [1:0] occ_after;
  logic       desc_err;
  logic [LEN_W-1:0] desc_len;

  assign desc_len = rx_ptr_fifo_dout[LEN_W-1:0];
  assign desc_err = rx_ptr_fifo_dout[12];

  assign out_valid = (occ_q != 2'd0);
  assign pop       = out_valid && out_ready;
  // Occupancy counts the byte leaving this cycle as gone, which keeps 1 byte/cycle flowing.
  assign occ_after = occ_q - {1'b0, pop} + {1'b0, infl_q};
  assign stream_rd = (state_q == STREAM) && (rem_q != '0) && (occ_after < 2'd2);
  assign drain_rd  = (state_q == DRAIN) && (rem_q != '0);
  assign ins_hi    = (occ_q > {1'b0, pop});

  assign out_data  = skid_q[0][7:0];
  assign out_eof   = skid_q[0][8];
  assign out_sof   = skid_q[0][9];
  assign out_meta  = meta_q;
  assign frame_cnt = frame_q;
  assign drop_cnt  = drop_q;

  always_ff @(posedge clk or negedge rstn_sys) begin
    if (!rstn_sys) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (!rx_ptr_fifo_empty) state_d = PTR_WAIT;
      PTR_WAIT: state_d = (desc_err || desc_len == '0) ? DRAIN : STREAM;
      STREAM:   if (pop && out_eof) state_d = DONE;
      DRAIN:    if (rem_q <= LEN_W'(1)) state_d = IDLE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    rx_ptr_fifo_rd  = (state_q == IDLE) && !rx_ptr_fifo_empty && rstn_sys;
    rx_data_fifo_rd = stream_rd || drain_rd;
  end

  always_comb begin
    rem_d      = rem_q;
    meta_d     = meta_q;
    sof_pend_d = sof_pend_q;
    skid_d     = skid_q;
    frame_d    = frame_q;
    drop_d     = drop_q;
    infl_d     = stream_rd;
    infl_sof_d = sof_pend_q;
    infl_eof_d = (rem_q == LEN_W'(1));
    occ_d      = occ_after;

    if (state_q == PTR_WAIT) begin
      rem_d      = desc_len;
      meta_d     = rx_ptr_fifo_dout[19:13];
      sof_pend_d = 1'b1;
    end
    if (rx_data_fifo_rd) rem_d = rem_q - LEN_W'(1);
    if (stream_rd) sof_pend_d = 1'b0;

    if (pop) skid_d[0] = skid_q[1];
    if (infl_q) skid_d[ins_hi] = {infl_sof_q, infl_eof_q, rx_data_fifo_dout};

    if (state_q == DONE) frame_d = frame_q + CNT_W'(1);
    if (state_q == DRAIN && rem_q <= LEN_W'(1)) drop_d = drop_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rstn_sys) begin
    if (!rstn_sys) begin
      rem_q      <= '0;
      meta_q     <= '0;
      sof_pend_q <= 1'b0;
      infl_q     <= 1'b0;
      infl_sof_q <= 1'b0;
      infl_eof_q <= 1'b0;
      occ_q      <= '0;
      skid_q     <= '0;
      frame_q    <= '0;
      drop_q     <= '0;
    end else begin
      rem_q      <= rem_d;
      meta_q     <= meta_d;
      sof_pend_q <= sof_pend_d;
      infl_q     <= infl_d;
      infl_sof_q <= infl_sof_d;
      infl_eof_q <= infl_eof_d;
      occ_q      <= occ_d;
      skid_q     <= skid_d;
      frame_q    <= frame_d;
      drop_q     <= drop_d;
    end
  end

endmodule

// File: tb/tb_mac_rx_frame_reader.sv
// tb/tb_mac_rx_frame_reader.sv - directed bench for mac_rx_frame_reader
// FIFO models feed descriptors and bytes; a monitor scoreboards every accepted byte.
module tb_mac_rx_frame_reader;

  logic        clk = 1'b0;
  logic        rstn_sys = 1'b0;
  logic        rx_ptr_fifo_rd;
  logic [19:0] rx_ptr_fifo_dout = '0;
  logic        rx_ptr_fifo_empty = 1'b1;
  logic        rx_data_fifo_rd;
  logic [7:0]  rx_data_fifo_dout = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_data;
  logic        out_sof;
  logic        out_eof;
  logic [6:0]  out_meta;
  logic [15:0] frame_cnt;
  logic [15:0] drop_cnt;

  mac_rx_frame_reader #(.LEN_W(12), .CNT_W(16)) dut (
    .clk               (clk),
    .rstn_sys          (rstn_sys),
    .rx_ptr_fifo_rd    (rx_ptr_fifo_rd),
    .rx_ptr_fifo_dout  (rx_ptr_fifo_dout),
    .rx_ptr_fifo_empty (rx_ptr_fifo_empty),
    .rx_data_fifo_rd   (rx_data_fifo_rd),
    .rx_data_fifo_dout (rx_data_fifo_dout),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_data          (out_data),
    .out_sof           (out_sof),
    .out_eof           (out_eof),
    .out_meta          (out_meta),
    .frame_cnt         (frame_cnt),
    .drop_cnt          (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int data_pops = 0;
  bit rand_ready = 1'b0;

  logic [19:0] ptr_q[$];
  logic [7:0]  data_q[$];
  logic [16:0] exp_q[$];

  bit          stall_prev = 1'b0;
  logic [16:0] held = '0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  always @(posedge clk) begin
    if (rx_ptr_fifo_rd) begin
      if (ptr_q.size() > 0) rx_ptr_fifo_dout <= ptr_q.pop_front();
      #1 rx_ptr_fifo_empty = (ptr_q.size() == 0);
    end
  end

  always @(posedge clk) begin
    if (rx_data_fifo_rd) begin
      data_pops++;
      if (data_q.size() > 0) rx_data_fifo_dout <= data_q.pop_front();
      else rx_data_fifo_dout <= 8'h00;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1 out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    logic [16:0] obs;
    logic [16:0] e;
    obs = {out_meta, out_sof, out_eof, out_data};
    if (!rstn_sys) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check_eq("stall_valid", 32'(out_valid), 32'd1);
        if (out_valid) check_eq("stall_hold", 32'(obs), 32'(held));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check_eq("unexpected_byte", 32'(obs), 32'h1ffff);
        else begin
          e = exp_q.pop_front();
          check_eq("byte", 32'(obs), 32'(e));
        end
      end
      stall_prev = out_valid && !out_ready;
      held = obs;
    end
  end

  task automatic add_frame(input logic [19:0] desc, input logic [7:0] seed);
    int len;
    bit good;
    logic [7:0] b;
    len = int'(desc[11:0]);
    good = !desc[12] && (len != 0);
    for (int i = 0; i < len; i++) begin
      b = seed + 8'(i);
      data_q.push_back(b);
      if (good) exp_q.push_back({desc[19:13], i == 0, i == len - 1, b});
    end
    ptr_q.push_back(desc);
    rx_ptr_fifo_empty = 1'b0;
  endtask

  task automatic do_reset();
    rstn_sys = 1'b0;
    #1;
    ptr_q.delete();
    data_q.delete();
    exp_q.delete();
    rx_ptr_fifo_empty = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_outputs",
             32'({out_valid, out_data, out_sof, out_eof, out_meta, rx_ptr_fifo_rd, rx_data_fifo_rd}),
             32'd0);
    check_eq("rst_counters", {frame_cnt, drop_cnt}, 32'd0);
    rstn_sys = 1'b1;
    data_pops = 0;
    @(negedge clk);
  endtask

  task automatic check_latency(input string tag);
    int lat;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    check_eq(tag, 32'(lat), 32'd4);
  endtask

  task automatic wait_done(input string tag, input logic [15:0] target, input int limit);
    for (int k = 0; k < limit; k++) begin
      if (frame_cnt == target && exp_q.size() == 0) break;
      @(negedge clk);
    end
    check_eq(tag, 32'(frame_cnt), 32'(target));
    check_eq({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    do_reset();

    add_frame(20'h00040, 8'h10);
    check_latency("t1_latency");
    wait_done("t1_frame_cnt", 16'd1, 400);
    check_eq("t1_pops", 32'(data_pops), 32'd64);

    do_reset();
    rand_ready = 1'b1;
    add_frame(20'h00040, 8'h10);
    wait_done("t2_frame_cnt", 16'd1, 1000);
    rand_ready = 1'b0;

    do_reset();
    add_frame(20'h01064, 8'h80);
    add_frame(20'h0003C, 8'h20);
    wait_done("t3_frame_cnt", 16'd1, 1000);
    check_eq("t3_drop_cnt", 32'(drop_cnt), 32'd1);
    check_eq("t3_pops", 32'(data_pops), 32'd160);

    do_reset();
    add_frame(20'h00000, 8'h00);
    add_frame(20'hAA001, 8'h5A);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("t4_drop_before", 32'(drop_cnt), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check_eq("t4_drop_cnt", 32'(drop_cnt), 32'd1);
    check_eq("t4_idle_pop", 32'(rx_ptr_fifo_rd), 32'd1);
    wait_done("t5_frame_cnt", 16'd1, 100);
    check_eq("t5_meta", 32'(out_meta), 32'h55);
    check_eq("t5_pops", 32'(data_pops), 32'd1);

    do_reset();
    add_frame(20'h005EA, 8'h01);
    add_frame(20'h005EA, 8'h02);
    add_frame(20'h005EA, 8'h03);
    for (int k = 0; k < 3000; k++) begin
      if (frame_cnt == 16'd1) break;
      @(negedge clk);
    end
    check_eq("t6_first_frame", 32'(frame_cnt), 32'd1);
    repeat (700) @(negedge clk);
    check_eq("t6_mid_frame2", 32'(frame_cnt), 32'd1);
    do_reset();
    repeat (3) @(negedge clk);
    check_eq("t6_idle", 32'({out_valid, rx_ptr_fifo_rd, rx_data_fifo_rd}), 32'd0);
    add_frame(20'h00001, 8'hC3);
    check_latency("t6_latency");
    wait_done("t6_frame_cnt", 16'd1, 100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
